// File: rtl/burst_ram.sv
// Single-port word RAM with a valid/ready burst command interface, byte strobes,
// wrapping auto-increment addressing and a sequenced clear of every word after reset.
module burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int BLEN_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CS,
  input  logic                    WE,
  input  logic [ADDR_WIDTH-1:0]   ADDR,
  input  logic [BLEN_WIDTH-1:0]   BLEN,
  output logic                    CMD_READY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    BUSY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [BLEN_WIDTH:0]   BEAT_ONE  = (BLEN_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   ptr_r;
  logic [BLEN_WIDTH-1:0]   remaining_r;
  logic [BLEN_WIDTH:0]     issued_r;
  logic                    cmd_ready_r;
  logic                    wready_r;
  logic                    rvalid_r;
  logic                    busy_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    wbeat_s;
  logic                    rissue_s;
  logic                    rlast_s;
  logic [BLEN_WIDTH:0]     beats_s;
  logic                    mem_we_s;
  logic [STRB_WIDTH-1:0]   mem_strb_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;

  assign CMD_READY = cmd_ready_r;
  assign WREADY    = wready_r;
  assign RVALID    = rvalid_r;
  assign RDATA     = rdata_r;
  assign BUSY      = busy_r;

  // Handshake qualifiers and the single memory write port (clear engine or write beats).
  always_comb begin
    wbeat_s     = 1'b0;
    rissue_s    = 1'b0;
    rlast_s     = 1'b0;
    beats_s     = {1'b0, remaining_r} + BEAT_ONE;
    mem_we_s    = 1'b0;
    mem_strb_s  = {STRB_WIDTH{1'b0}};
    mem_wdata_s = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_INIT: begin
        mem_we_s   = !RST;
        mem_strb_s = {STRB_WIDTH{1'b1}};
      end
      ST_WRITE: begin
        wbeat_s     = WVALID && wready_r;
        mem_we_s    = wbeat_s && !RST;
        mem_strb_s  = WSTRB;
        mem_wdata_s = WDATA;
      end
      ST_READ: begin
        // A new beat may enter the output register when it is empty or being drained.
        rissue_s = (!rvalid_r || RREADY) && (issued_r < beats_s);
        rlast_s  = rvalid_r && RREADY && (issued_r == beats_s);
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Byte-lane storage write; contents are not reset, the clear engine zeroes them.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (mem_we_s && mem_strb_s[i]) begin
        mem_r[ptr_r][8*i +: 8] <= mem_wdata_s[8*i +: 8];
      end
    end
  end

  // Burst sequencer with registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_INIT;
      ptr_r       <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {BLEN_WIDTH{1'b0}};
      issued_r    <= {(BLEN_WIDTH+1){1'b0}};
      cmd_ready_r <= 1'b0;
      wready_r    <= 1'b0;
      rvalid_r    <= 1'b0;
      rdata_r     <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          ptr_r <= ptr_r + ADDR_ONE;
          if (ptr_r == ADDR_LAST) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (CS) begin
            ptr_r       <= ADDR;
            remaining_r <= BLEN;
            issued_r    <= {(BLEN_WIDTH+1){1'b0}};
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (WE) begin
              state_r  <= ST_WRITE;
              wready_r <= 1'b1;
            end else begin
              state_r  <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (wbeat_s) begin
            ptr_r <= ptr_r + ADDR_ONE;
            if (remaining_r == {BLEN_WIDTH{1'b0}}) begin
              state_r     <= ST_IDLE;
              wready_r    <= 1'b0;
              cmd_ready_r <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              remaining_r <= remaining_r - BLEN_WIDTH'(1);
            end
          end
        end
        ST_READ: begin
          if (rlast_s) begin
            rvalid_r    <= 1'b0;
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else if (rissue_s) begin
            rdata_r  <= mem_r[ptr_r];
            rvalid_r <= 1'b1;
            ptr_r    <= ptr_r + ADDR_ONE;
            issued_r <= issued_r + BEAT_ONE;
          end
        end
        default: begin
          state_r     <= ST_INIT;
          ptr_r       <= {ADDR_WIDTH{1'b0}};
          cmd_ready_r <= 1'b0;
          wready_r    <= 1'b0;
          rvalid_r    <= 1'b0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram: clear-on-reset, single beats, strobes, wrap,
// backpressure on both channels and reset in the middle of a write burst.
module tb_burst_ram;

  logic        CLK;
  logic        RST;
  logic        CS;
  logic        WE;
  logic [5:0]  ADDR;
  logic [3:0]  BLEN;
  logic        CMD_READY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        BUSY;

  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  int          cyc_o;
  logic [31:0] acc;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rdq [$];

  burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BLEN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .BLEN(BLEN),
    .CMD_READY(CMD_READY), .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID),
    .WREADY(WREADY), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic init_wait(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!CMD_READY && n < 200);
    chk(tag, 32'(n), 32'd64);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic issue_cmd(input logic w, input logic [5:0] a, input logic [3:0] b);
    int k = 0;
    CS = 1'b1; WE = w; ADDR = a; BLEN = b; RREADY = 1'b0; WVALID = 1'b0;
    while (!CMD_READY && k < 100) begin
      tick();
      k++;
    end
    chk("cmd_ready", {31'd0, CMD_READY}, 32'd1);
    tick();
    CS = 1'b0;
    chk("busy_after_accept", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [3:0] b, input logic [15:0] gaps);
    issue_cmd(1'b1, a, b);
    for (int i = 0; i <= int'(b); i++) begin
      if (gaps[i]) begin
        WVALID = 1'b0;
        tick();
      end
      WVALID = 1'b1; WDATA = wd[i]; WSTRB = ws[i];
      chk("wready", {31'd0, WREADY}, 32'd1);
      tick();
    end
    WVALID = 1'b0;
    chk("write_done_idle", {31'd0, CMD_READY}, 32'd1);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [3:0] b, input logic [15:0] rmask,
                         output int cycles);
    int          got = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'd0;
    rdq.delete();
    issue_cmd(1'b0, a, b);
    while (got < int'(b) + 1 && cyc < 300) begin
      RREADY = rmask[cyc % 16];
      if (prev_stall) begin
        chk("stall_rdata_hold", RDATA, prev_data);
        chk("stall_rvalid_hold", {31'd0, RVALID}, 32'd1);
      end
      if (RVALID && RREADY) begin
        rdq.push_back(RDATA);
        got++;
      end
      prev_stall = RVALID && !RREADY;
      prev_data  = RDATA;
      tick();
      cyc++;
    end
    RREADY = 1'b0;
    cycles = cyc;
    chk("read_beats", 32'(got), 32'(int'(b) + 1));
    chk("read_done_rvalid", {31'd0, RVALID}, 32'd0);
    chk("read_done_idle", {31'd0, CMD_READY}, 32'd1);
  endtask

  initial begin
    RST = 1'b1; CS = 1'b0; WE = 1'b0; ADDR = 6'd0; BLEN = 4'd0;
    WDATA = 32'd0; WSTRB = 4'd0; WVALID = 1'b0; RREADY = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd1);
    chk("rst_wready", {31'd0, WREADY}, 32'd0);
    chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    RST = 1'b0;
    init_wait("init_edges");

    // Fill the whole array with ones, confirm, then reset and expect all zeros.
    for (int i = 0; i < 16; i++) begin
      wd[i] = 32'hFFFF_FFFF;
      ws[i] = 4'hF;
    end
    for (int s = 0; s < 4; s++) do_write(6'(s * 16), 4'd15, 16'h0000);
    do_read(6'd20, 4'd0, 16'hFFFF, cyc_o);
    chk("fill_ones", rdq[0], 32'hFFFF_FFFF);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("pulse_cmd_ready", {31'd0, CMD_READY}, 32'd0);
    chk("pulse_busy", {31'd0, BUSY}, 32'd1);
    init_wait("reinit_edges");
    acc = 32'd0;
    for (int s = 0; s < 4; s++) begin
      do_read(6'(s * 16), 4'd15, 16'hFFFF, cyc_o);
      chk("zero_read_cycles", 32'(cyc_o), 32'd17);
      foreach (rdq[i]) acc = acc | rdq[i];
    end
    chk("cleared_all_zero", acc, 32'd0);

    // Single beat with first-beat latency and held RDATA after the burst.
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(6'd5, 4'd0, 16'h0000);
    do_read(6'd5, 4'd0, 16'hFFFF, cyc_o);
    chk("single_data", rdq[0], 32'hDEAD_BEEF);
    chk("single_cycles", 32'(cyc_o), 32'd2);
    chk("single_rdata_keep", RDATA, 32'hDEAD_BEEF);

    // Byte strobes merge into the existing word.
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(6'd9, 4'd0, 16'h0000);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(6'd9, 4'd0, 16'h0000);
    do_read(6'd9, 4'd0, 16'hFFFF, cyc_o);
    chk("strobe_merge", rdq[0], 32'h11BB_33DD);

    // Address wrap from the top of the array.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1);
      ws[i] = 4'hF;
    end
    do_write(6'd62, 4'd3, 16'h0000);
    do_read(6'd62, 4'd3, 16'hFFFF, cyc_o);
    chk("wrap_b0", rdq[0], 32'd1);
    chk("wrap_b1", rdq[1], 32'd2);
    chk("wrap_b2", rdq[2], 32'd3);
    chk("wrap_b3", rdq[3], 32'd4);
    chk("wrap_cycles", 32'(cyc_o), 32'd5);
    do_read(6'd0, 4'd1, 16'hFFFF, cyc_o);
    chk("wrap_word0", rdq[0], 32'd3);
    chk("wrap_word1", rdq[1], 32'd4);

    // Write with WVALID gaps, read with RREADY toggling.
    for (int i = 0; i < 8; i++) begin
      wd[i] = 32'h0000_0100 + 32'(i);
      ws[i] = 4'hF;
    end
    do_write(6'd20, 4'd7, 16'h00A5);
    do_read(6'd20, 4'd7, 16'h5555, cyc_o);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_beat%0d", i), rdq[i], 32'h0000_0100 + 32'(i));
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'h0;
    do_write(6'd20, 4'd0, 16'h0000);
    do_read(6'd20, 4'd0, 16'hFFFF, cyc_o);
    chk("zero_strobe_nochange", rdq[0], 32'h0000_0100);

    // Reset in the middle of a four-beat write burst.
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    issue_cmd(1'b1, 6'd0, 4'd3);
    WVALID = 1'b1; WSTRB = 4'hF; WDATA = wd[0];
    tick();
    WDATA = wd[1];
    tick();
    WDATA = wd[2]; RST = 1'b1;
    tick();
    RST = 1'b0; WVALID = 1'b0;
    chk("midrst_wready", {31'd0, WREADY}, 32'd0);
    chk("midrst_cmd_ready", {31'd0, CMD_READY}, 32'd0);
    chk("midrst_busy", {31'd0, BUSY}, 32'd1);
    init_wait("midrst_init_edges");
    do_read(6'd0, 4'd3, 16'hFFFF, cyc_o);
    acc = 32'd0;
    foreach (rdq[i]) acc = acc | rdq[i];
    chk("midrst_cleared", acc, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
